key_conditioner: RTL and testbench

- Pushbutton front end that sits directly upstream of the clock interface and feeds its iKEY bus.
- Synchronizes the raw active-low DE-board KEY pins into iCLK_50 and debounces each key independently.
- Outputs a clean active-low level per key, plus one-cycle press and release strobes.
- Removes bounce-induced extra toggles of manual clock, auto/manual select and slow/fast select.

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_debounce_cell.sv | 174 +++++++++++++++++
 rtl/key_conditioner.sv | 57 +++++
 tb/tb_key_conditioner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the pushbutton conditioning front end.
//
// Contents:
//   key_state_t   - per-key debounce state (STABLE, QUALIFY)
//   CLK_HZ        - frequency of the system clock the keys are sampled on
//   ms_to_cycles  - converts a time in milliseconds into CLK_HZ cycles, used
//                   to derive the default debounce and repeat parameters
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic {
        STABLE,
        QUALIFY
    } key_state_t;

    localparam int unsigned CLK_HZ = 50000000;

    // Milliseconds to clock cycles at CLK_HZ. The CLK_HZ/1000 factor is exact
    // for the 50 MHz board clock, so no rounding is needed.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// -----------------------------------------------------------------------------
// key_debounce_cell
// Conditions a single pushbutton: two-flop synchronizer, STABLE/QUALIFY
// debounce FSM with a consecutive-stable-cycles counter, and registered
// one-cycle press/release strobes coincident with the level update.
//
// Build option: KEY_AUTOREPEAT_EN adds a hold counter that re-issues the
// press strobe REPEAT_DELAY cycles after a press and then every
// REPEAT_PERIOD cycles while the key stays held.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   key_raw        in   raw pin, active-low, asynchronous to clk
//   key_level      out  debounced level, active-low (1 = released)
//   press_strobe   out  one-cycle pulse when a press is accepted (or repeats)
//   release_strobe out  one-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(20)
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = ms_to_cycles(500),
    parameter int unsigned REPEAT_PERIOD   = ms_to_cycles(100)
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_strobe,
    output logic release_strobe
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1 before it is cleared,
    // so clog2(DEBOUNCE_CYCLES) bits are enough and it can never wrap.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_meta;
    logic             sync_sample;
    key_state_t       state;
    key_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             press_next;
    logic             release_next;
    logic             press_d;

    // Synchronizer, debounce state and registered outputs. Reset parks the
    // chain at "released" so that no strobe can be generated out of reset
    // until a real low level has been sampled for the full qualify window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta      <= 1'b1;
            sync_sample    <= 1'b1;
            state          <= STABLE;
            cnt            <= '0;
            key_level      <= 1'b1;
            press_strobe   <= 1'b0;
            release_strobe <= 1'b0;
        end else begin
            sync_meta      <= key_raw;
            sync_sample    <= sync_meta;
            state          <= state_next;
            cnt            <= cnt_next;
            key_level      <= level_next;
            press_strobe   <= press_d;
            release_strobe <= release_next;
        end
    end

    // Debounce FSM. A differing sample opens a qualify window with the count
    // already at 1; any sample that matches the current level during the
    // window is treated as bounce and abandons it. The decision in the final
    // cycle uses that cycle's sample, so a glitch landing there cannot slip
    // through. Press and release strobes are derived from the accepted level
    // and therefore are mutually exclusive by construction.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = key_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            STABLE: begin
                if (sync_sample != key_level) begin
                    state_next = QUALIFY;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            QUALIFY: begin
                if (sync_sample == key_level) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = STABLE;
                    cnt_next     = '0;
                    level_next   = sync_sample;
                    press_next   = ~sync_sample;
                    release_next = sync_sample;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic              repeating;
    logic              repeating_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              repeat_fire;

    // Hold counter state. It sits at zero while the key is released, so the
    // first counted cycle is the one right after the accepted press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_next;
            repeating <= repeating_next;
        end
    end

    // Auto-repeat timing. The counter only advances while the key is held
    // and the cell is settled in STABLE; it pauses while a release is being
    // qualified, which keeps repeat strobes away from the release strobe.
    // The first interval is REPEAT_DELAY, every later one REPEAT_PERIOD.
    always_comb begin
        hold_cnt_next  = hold_cnt;
        repeating_next = repeating;
        repeat_fire    = 1'b0;
        if (key_level) begin
            hold_cnt_next  = '0;
            repeating_next = 1'b0;
        end else if (state == STABLE) begin
            if ((!repeating && hold_cnt == DELAY_LAST) ||
                ( repeating && hold_cnt == PERIOD_LAST)) begin
                repeat_fire    = 1'b1;
                hold_cnt_next  = '0;
                repeating_next = 1'b1;
            end else begin
                hold_cnt_next  = hold_cnt + HOLD_ONE;
            end
        end
    end

    // A repeat can only fire while the level is already low, and an accepted
    // press only while it is still high, so the two never overlap.
    assign press_d = press_next | repeat_fire;
`else
    assign press_d = press_next;
`endif

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Pushbutton front end for the DE-board KEY pins. Each key is synchronized
// into iCLK_50 and debounced independently by its own key_debounce_cell,
// giving a clean active-low level plus one-cycle press/release strobes.
//
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat press strobes while a
// key is held (REPEAT_DELAY / REPEAT_PERIOD exist only in that build).
//
// Ports:
//   iCLK_50   in   [1]         system clock, 50 MHz
//   Reset     in   [1]         synchronous, active-high reset
//   iKEY_RAW  in   [NUM_KEYS]  raw pushbutton pins, active-low, asynchronous
//   oKEY      out  [NUM_KEYS]  debounced level, active-low (1 = released)
//   oPress    out  [NUM_KEYS]  one-cycle strobe on accepted press
//   oRelease  out  [NUM_KEYS]  one-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(20)
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = ms_to_cycles(500),
    parameter int unsigned REPEAT_PERIOD   = ms_to_cycles(100)
`endif
) (
    input  logic                iCLK_50,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] iKEY_RAW,
    output logic [NUM_KEYS-1:0] oKEY,
    output logic [NUM_KEYS-1:0] oPress,
    output logic [NUM_KEYS-1:0] oRelease
);

    // One fully independent cell per key; keys changing together each
    // qualify on their own and can strobe in the same cycle.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_cell (
            .clk            (iCLK_50),
            .reset          (Reset),
            .key_raw        (iKEY_RAW[k]),
            .key_level      (oKEY[k]),
            .press_strobe   (oPress[k]),
            .release_strobe (oRelease[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=8, so a clean pin
// edge shows up on oKEY 10 clock edges later. Inputs change 1 time unit after
// a rising edge and outputs are sampled at that same point.
// Build option: KEY_AUTOREPEAT_EN adds the auto-repeat sequence.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 6;

    logic          iCLK_50;
    logic          Reset;
    logic [NK-1:0] iKEY_RAW;
    logic [NK-1:0] oKEY;
    logic [NK-1:0] oPress;
    logic [NK-1:0] oRelease;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string      name;
        logic [3:0] raw;
        int         cycles;
        logic [3:0] exp_key;
        logic [3:0] exp_press;
        logic [3:0] exp_release;
        logic [3:0] exp_press_seen;
        logic [3:0] exp_release_seen;
    } vec_t;

    vec_t vecs[$];

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .iCLK_50  (iCLK_50),
        .Reset    (Reset),
        .iKEY_RAW (iKEY_RAW),
        .oKEY     (oKEY),
        .oPress   (oPress),
        .oRelease (oRelease)
    );

    // 10-unit clock period
    initial iCLK_50 = 1'b0;
    always #5 iCLK_50 = ~iCLK_50;

    // Drive raw pins, run a number of edges and OR together every strobe seen
    // so that "no strobe anywhere in this window" can be checked.
    task automatic applyStimulus(input logic [3:0] raw, input int cycles,
                                 output logic [3:0] press_seen, output logic [3:0] release_seen);
        iKEY_RAW     = raw;
        press_seen   = '0;
        release_seen = '0;
        repeat (cycles) begin
            @(posedge iCLK_50);
            #1;
            press_seen   = press_seen | oPress;
            release_seen = release_seen | oRelease;
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic [3:0] raw, input int cycles,
                          input logic [3:0] k, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] ps, input logic [3:0] rs);
        vec_t v;
        v.name             = name;
        v.raw              = raw;
        v.cycles           = cycles;
        v.exp_key          = k;
        v.exp_press        = p;
        v.exp_release      = r;
        v.exp_press_seen   = ps;
        v.exp_release_seen = rs;
        vecs.push_back(v);
    endtask

    // Main sequence: reset corner case, the vector table, then the
    // multi-cycle reset-during-qualify case and the optional repeat case.
    initial begin
        logic [3:0] ps;
        logic [3:0] rs;

        // Each record runs from the state the previous one left behind.
        addVec("rel_all_wait",  4'b1111, 9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("rel_all_edge",  4'b1111, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
        addVec("rel_all_after", 4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k3_press_wait", 4'b0111, 9, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k3_press_edge", 4'b0111, 1, 4'b0111, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        addVec("k3_press_once", 4'b0111, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k3_rel_wait",   4'b1111, 9, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k3_rel_edge",   4'b1111, 1, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        addVec("k1_bounce_a",   4'b1101, 3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_bounce_b",   4'b1111, 3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_bounce_c",   4'b1101, 3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_bounce_d",   4'b1111, 3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_settle",     4'b1101, 9, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_press_edge", 4'b1101, 1, 4'b1101, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
        addVec("k1_press_once", 4'b1101, 1, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_rel_wait",   4'b1111, 9, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k1_rel_edge",   4'b1111, 1, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        addVec("k2_glitch7",    4'b1011, 7, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k2_glitch7_end",4'b1111,10, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k2_low8",       4'b1011, 8, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k2_low8_press", 4'b1111, 2, 4'b1011, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        addVec("k2_rel_wait",   4'b1111, 7, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k2_rel_edge",   4'b1111, 1, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
        addVec("k02_wait",      4'b1010, 9, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k02_press",     4'b1010, 1, 4'b1010, 4'b0101, 4'b0000, 4'b0101, 4'b0000);
        addVec("k02_rel_wait",  4'b1111, 9, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        addVec("k02_rel_edge",  4'b1111, 1, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b0101);
        addVec("idle",          4'b1111, 2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset held for 3 edges with every pin low: outputs stay released.
        Reset    = 1'b1;
        iKEY_RAW = 4'b0000;
        applyStimulus(4'b0000, 3, ps, rs);
        checkOutput("reset.key", oKEY, 4'b1111);
        checkOutput("reset.press_seen", ps, 4'b0000);
        checkOutput("reset.release_seen", rs, 4'b0000);

        // After release all four keys qualify together on edge 10.
        Reset = 1'b0;
        applyStimulus(4'b0000, 9, ps, rs);
        checkOutput("post_reset.key_e9", oKEY, 4'b1111);
        checkOutput("post_reset.press_seen_e9", ps, 4'b0000);
        applyStimulus(4'b0000, 1, ps, rs);
        checkOutput("post_reset.key_e10", oKEY, 4'b0000);
        checkOutput("post_reset.press_e10", oPress, 4'b1111);
        checkOutput("post_reset.release_e10", oRelease, 4'b0000);

        $display("[TB] running %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].raw, vecs[i].cycles, ps, rs);
            checkOutput({vecs[i].name, ".key"}, oKEY, vecs[i].exp_key);
            checkOutput({vecs[i].name, ".press"}, oPress, vecs[i].exp_press);
            checkOutput({vecs[i].name, ".release"}, oRelease, vecs[i].exp_release);
            checkOutput({vecs[i].name, ".press_seen"}, ps, vecs[i].exp_press_seen);
            checkOutput({vecs[i].name, ".release_seen"}, rs, vecs[i].exp_release_seen);
        end

        // Reset while key 1 is at cnt=5: the partial count must be lost, so
        // the key needs a full 10 edges after reset to be accepted.
        applyStimulus(4'b1101, 7, ps, rs);
        checkOutput("midreset.key_before", oKEY, 4'b1111);
        Reset = 1'b1;
        applyStimulus(4'b1101, 1, ps, rs);
        checkOutput("midreset.key_in_reset", oKEY, 4'b1111);
        checkOutput("midreset.press_in_reset", ps, 4'b0000);
        Reset = 1'b0;
        applyStimulus(4'b1101, 9, ps, rs);
        checkOutput("midreset.key_e9", oKEY, 4'b1111);
        checkOutput("midreset.press_seen_e9", ps, 4'b0000);
        applyStimulus(4'b1101, 1, ps, rs);
        checkOutput("midreset.key_e10", oKEY, 4'b1101);
        checkOutput("midreset.press_e10", oPress, 4'b0010);
        applyStimulus(4'b1111, 10, ps, rs);
        checkOutput("midreset.key_released", oKEY, 4'b1111);
        checkOutput("midreset.release_seen", rs, 4'b0010);

`ifdef KEY_AUTOREPEAT_EN
        // Hold key 0 for 56 edges: press at 10, repeats at 30, 36, 42, 48, 54.
        // Release then qualifies on edge 66 with no further repeats.
        begin
            int press_edges[$];
            int exp_edges[6];
            int press_after;
            int release_after;
            int release_edge;
            exp_edges = '{10, 30, 36, 42, 48, 54};
            iKEY_RAW = 4'b1110;
            for (int e = 1; e <= 56; e++) begin
                @(posedge iCLK_50);
                #1;
                if (oPress[0]) press_edges.push_back(e);
            end
            checkValue("repeat.count", press_edges.size(), 6);
            for (int i = 0; i < 6; i++) begin
                if (i < press_edges.size()) checkValue($sformatf("repeat.edge%0d", i), press_edges[i], exp_edges[i]);
            end
            iKEY_RAW      = 4'b1111;
            press_after   = 0;
            release_after = 0;
            release_edge  = 0;
            for (int e = 57; e <= 70; e++) begin
                @(posedge iCLK_50);
                #1;
                if (oPress[0]) press_after++;
                if (oRelease[0]) begin
                    release_after++;
                    release_edge = e;
                end
            end
            checkValue("repeat.press_after_release", press_after, 0);
            checkValue("repeat.release_count", release_after, 1);
            checkValue("repeat.release_edge", release_edge, 66);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
